feature_buf_4: RTL and testbench

FEATURE_BUF_4 -- requirements
Module: feature_buf_4

---
 rtl/feature_buf_4.sv | 130 +++++++++++++
 tb/tb_feature_buf_4.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_buf_4.sv
// Frame capture buffer feeding layer 4: collects one frame of pooled samples,
// then serves registered random-access reads until the frame is restarted.
module feature_buf_4 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 144,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_4_begin,
    input  logic [DATA_W-1:0] d_in,
    input  logic              d_in_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic [ADDR_W-1:0] sample_count,
    output logic              buf_full,
    output logic              buf_write_complete,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sample_count_q, sample_count_d;
    logic                overflow_q, overflow_d;
    logic                write_complete_q, write_complete_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_data_valid_q, rd_data_valid_d;
    logic                wr_en;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Capture control: a restart always wins over an incoming sample.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d          = state_q;
        sample_count_d   = sample_count_q;
        overflow_d       = overflow_q;
        write_complete_d = 1'b0;
        wr_en            = 1'b0;
        case (state_q)
            IDLE: begin
                if (layer_4_begin) begin
                    state_d        = FILL;
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            FILL: begin
                if (layer_4_begin) begin
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end else if (d_in_valid) begin
                    wr_en          = 1'b1;
                    sample_count_d = sample_count_q + 1'b1;
                    if (sample_count_q == LAST_IDX) begin
                        state_d          = FULL;
                        write_complete_d = 1'b1;
                    end
                end
            end
            FULL: begin
                if (layer_4_begin) begin
                    state_d        = FILL;
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end else if (d_in_valid) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads look at the pre-edge state, so a read alongside a restart still hits the old frame.
    always_comb begin
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;
        if (rd_en) begin
            if (state_q == FULL && rd_addr < DEPTH_A) begin
                rd_data_d       = mem_q[rd_addr];
                rd_data_valid_d = 1'b1;
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            sample_count_q   <= '0;
            overflow_q       <= 1'b0;
            write_complete_q <= 1'b0;
            rd_data_q        <= '0;
            rd_data_valid_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            sample_count_q   <= sample_count_d;
            overflow_q       <= overflow_d;
            write_complete_q <= write_complete_d;
            rd_data_q        <= rd_data_d;
            rd_data_valid_q  <= rd_data_valid_d;
        end
    end

    // NOTE: the sample array is deliberately not reset; it is only read after a full frame is written.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[sample_count_q] <= d_in;
        end
    end

    assign rd_data            = rd_data_q;
    assign rd_data_valid      = rd_data_valid_q;
    assign sample_count       = sample_count_q;
    assign buf_full           = (state_q == FULL);
    assign buf_write_complete = write_complete_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_feature_buf_4.sv
// Self-checking bench for feature_buf_4: vector table, directed frame sequences,
// and a randomized run compared cycle by cycle against a frame-level model.
module tb_feature_buf_4;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 144;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              layer_4_begin;
    logic [DATA_W-1:0] d_in;
    logic              d_in_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic [ADDR_W-1:0] sample_count;
    logic              buf_full;
    logic              buf_write_complete;
    logic              overflow;

    feature_buf_4 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .layer_4_begin      (layer_4_begin),
        .d_in               (d_in),
        .d_in_valid         (d_in_valid),
        .rd_en              (rd_en),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .rd_data_valid      (rd_data_valid),
        .sample_count       (sample_count),
        .buf_full           (buf_full),
        .buf_write_complete (buf_write_complete),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int wc_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-level model: a capture is "armed" after a begin; the frame is full once DEPTH samples landed.
    int m_mem [DEPTH];
    int m_count;
    bit m_armed;
    bit m_overflow;
    int m_rd_data;
    bit m_rd_valid;
    bit m_wc;

    function automatic void model_reset();
        m_count    = 0;
        m_armed    = 1'b0;
        m_overflow = 1'b0;
        m_rd_data  = 0;
        m_rd_valid = 1'b0;
        m_wc       = 1'b0;
    endfunction

    function automatic void model_step(bit b, bit dv, int din, bit ren, int ra);
        bit was_full;
        was_full = m_armed && (m_count == DEPTH);
        m_rd_valid = 1'b0;
        if (ren) begin
            if (was_full && ra < DEPTH) begin
                m_rd_data  = m_mem[ra];
                m_rd_valid = 1'b1;
            end else begin
                m_rd_data = 0;
            end
        end
        m_wc = 1'b0;
        if (b) begin
            m_armed    = 1'b1;
            m_count    = 0;
            m_overflow = 1'b0;
        end else if (m_armed && dv) begin
            if (m_count < DEPTH) begin
                m_mem[m_count] = din;
                m_count++;
                if (m_count == DEPTH) m_wc = 1'b1;
            end else begin
                m_overflow = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit b, input bit dv, input logic [7:0] din,
                        input bit ren, input logic [7:0] ra);
        layer_4_begin = b;
        d_in_valid    = dv;
        d_in          = din;
        rd_en         = ren;
        rd_addr       = ra;
        model_step(b, dv, int'(din), ren, int'(ra));
        @(posedge clk);
        #1;
        if (buf_write_complete) wc_seen++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input bit dv, input logic [7:0] din, input bit ren, input logic [7:0] ra);
        rst           = 1'b0;
        layer_4_begin = 1'b0;
        d_in_valid    = dv;
        d_in          = din;
        rd_en         = ren;
        rd_addr       = ra;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_full"},  buf_full, 0);
        check({tag, "_wc"},    buf_write_complete, 0);
        check({tag, "_ovf"},   overflow, 0);
        check({tag, "_cnt"},   sample_count, 0);
        check({tag, "_rv"},    rd_data_valid, 0);
        check({tag, "_rd"},    rd_data, 0);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_full"}, buf_full, (m_armed && m_count == DEPTH) ? 1 : 0);
        check({tag, "_wc"},   buf_write_complete, m_wc);
        check({tag, "_ovf"},  overflow, m_overflow);
        check({tag, "_cnt"},  sample_count, m_count);
        check({tag, "_rv"},   rd_data_valid, m_rd_valid);
        check({tag, "_rd"},   rd_data, m_rd_data);
    endtask

    typedef struct {
        bit         b;
        bit         dv;
        logic [7:0] din;
        bit         ren;
        logic [7:0] ra;
        bit         e_full;
        bit         e_wc;
        bit         e_ovf;
        logic [7:0] e_cnt;
        bit         e_rv;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Short directed vectors starting right after reset (idle strobes, begin, writes, restart).
        vecs[0] = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h55, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 8'h33, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 8'h44, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00};

        rst = 1'b0;
        layer_4_begin = 1'b0;
        d_in_valid = 1'b0;
        d_in = '0;
        rd_en = 1'b0;
        rd_addr = '0;
        model_reset();
        do_reset(1'b0, 8'h00, 1'b0, 8'h00);
        do_reset(1'b0, 8'h00, 1'b0, 8'h00);
        check_reset_state("reset");

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].b, vecs[i].dv, vecs[i].din, vecs[i].ren, vecs[i].ra);
            check($sformatf("vec%0d_full", i), buf_full, vecs[i].e_full);
            check($sformatf("vec%0d_wc", i),   buf_write_complete, vecs[i].e_wc);
            check($sformatf("vec%0d_ovf", i),  overflow, vecs[i].e_ovf);
            check($sformatf("vec%0d_cnt", i),  sample_count, vecs[i].e_cnt);
            check($sformatf("vec%0d_rv", i),   rd_data_valid, vecs[i].e_rv);
            check($sformatf("vec%0d_rd", i),   rd_data, vecs[i].e_rd);
        end

        // Full frame: one strobe every 4 cycles, d_in = index.
        wc_seen = 0;
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("fill_begin_cnt", sample_count, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
            if (i == DEPTH - 2) check("fill_not_full_early", buf_full, 0);
            if (i == DEPTH - 1) begin
                check("fill_full_on_last_edge", buf_full, 1);
                check("fill_wc_pulse", buf_write_complete, 1);
                check("fill_cnt", sample_count, DEPTH);
            end
            idle(3);
        end
        check("fill_wc_once", wc_seen, 1);
        check("fill_wc_low_after", buf_write_complete, 0);
        check("fill_full_held", buf_full, 1);

        // Reads at the frame boundaries, out-of-range, and hold on rd_en=0.
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
        check("rd0_data", rd_data, 0);
        check("rd0_valid", rd_data_valid, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd77);
        check("rd77_data", rd_data, 77);
        check("rd77_valid", rd_data_valid, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd143);
        check("rd143_data", rd_data, 143);
        check("rd143_valid", rd_data_valid, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd144);
        check("rd144_data", rd_data, 0);
        check("rd144_valid", rd_data_valid, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd77);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'd3);
        check("rd_hold_data", rd_data, 77);
        check("rd_hold_valid", rd_data_valid, 0);

        // Extra strobe after full sets overflow and leaves the frame intact.
        step(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        check("ovf_set", overflow, 1);
        check("ovf_cnt", sample_count, DEPTH);
        check("ovf_full", buf_full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 8'(i));
            check($sformatf("ovf_mem%0d", i), rd_data, i);
        end
        check("ovf_sticky", overflow, 1);

        // Read together with a restart is served from the old frame.
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'd5);
        check("rdrst_data", rd_data, 5);
        check("rdrst_valid", rd_data_valid, 1);
        check("rdrst_full", buf_full, 0);
        check("rdrst_cnt", sample_count, 0);
        check("rdrst_ovf", overflow, 0);

        // Partial frame, restart with a strobe present, then a clean refill.
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 8'(i + 100), 1'b0, 8'h00);
        check("part_cnt", sample_count, 50);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 8'h00);
        check("restart_cnt", sample_count, 0);
        check("restart_full", buf_full, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i * 3 + 7), 1'b0, 8'h00);
        check("refill_full", buf_full, 1);
        check("refill_cnt", sample_count, DEPTH);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
        check("refill_rd0", rd_data, 7);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd50);
        check("refill_rd50", rd_data, 157);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd143);
        check("refill_rd143", rd_data, 180);

        // Reset during a fill abandons the frame until the next begin.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        check("midrst_pre_cnt", sample_count, 100);
        do_reset(1'b1, 8'h99, 1'b1, 8'd3);
        check_reset_state("midrst");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        check("postrst_cnt", sample_count, 0);
        check("postrst_full", buf_full, 0);
        check("postrst_ovf", overflow, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'd3);
        check("postrst_rv", rd_data_valid, 0);

        // Randomized traffic compared against the frame model every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(999) == 0) begin
                do_reset($urandom_range(1), 8'($urandom), $urandom_range(1), 8'($urandom_range(159)));
            end else begin
                step($urandom_range(399) == 0,
                     $urandom_range(1),
                     8'($urandom),
                     $urandom_range(2) == 0,
                     8'($urandom_range(159)));
            end
            cmp_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
